// File: rtl/csla_pkg.sv
// Shared constants, stage-count helper and per-stage payload for the segmented carry-select pipeline.
package csla_pkg;

  localparam int CSLA_WIDTH = 16;
  localparam int CSLA_SEG   = 4;

  function automatic int csla_nseg(input int width, input int seg);
    return width / seg;
  endfunction

  // Payload carried by every stage: lower sum segments resolved so far, full operands
  // (upper segments still pending) and the carry into the next unresolved segment.
  typedef struct packed {
    logic                  valid;
    logic [CSLA_WIDTH-1:0] sum;
    logic [CSLA_WIDTH-1:0] a;
    logic [CSLA_WIDTH-1:0] b;
    logic                  carry;
  } csla_stage_t;

endpackage

// File: rtl/seg_rca.sv
// SEG-bit ripple-carry adder with carry-in tied to 0; returns the raw sum Z and carry rc.
module seg_rca #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  output logic [SEG-1:0] o_z,
  output logic           o_rc
);

  always_comb begin : p_ripple
    logic w_c;
    w_c  = 1'b0;
    o_z  = '0;
    for (int i = 0; i < SEG; i++) begin
      o_z[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_rc = w_c;
  end

endmodule

// File: rtl/csla_seg_pipe.sv
// Segment-per-stage pipelined adder with valid/ready flow control and bubble collapsing.
// Optional signed-overflow output ovf when CSLA_SEG_PIPE_OVF_EN is defined; WIDTH/SEG must match csla_pkg.
module csla_seg_pipe
  import csla_pkg::*;
#(
  parameter int WIDTH = CSLA_WIDTH,
  parameter int SEG   = CSLA_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSLA_SEG_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = csla_nseg(WIDTH, SEG);

  csla_stage_t      r_stg [NSEG];
  csla_stage_t      w_src [NSEG];
  csla_stage_t      w_nxt [NSEG];
  logic [WIDTH-1:0] w_z;
  logic [NSEG-1:0]  w_rc;
  logic [NSEG-1:0]  w_adv;
  logic [NSEG-1:0]  w_load;

  // Stage k consumes stage k-1's register; stage 0 consumes the input port.
  always_comb begin
    w_src[0].valid = in_valid;
    w_src[0].sum   = '0;
    w_src[0].a     = a;
    w_src[0].b     = b;
    w_src[0].carry = cin;
    for (int k = 1; k < NSEG; k++) begin
      w_src[k] = r_stg[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    seg_rca #(.SEG(SEG)) u_rca (
      .i_a  (w_src[k].a[k*SEG +: SEG]),
      .i_b  (w_src[k].b[k*SEG +: SEG]),
      .o_z  (w_z[k*SEG +: SEG]),
      .o_rc (w_rc[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      w_nxt[k] = w_src[k];
      w_nxt[k].sum[k*SEG +: SEG] = w_z[k*SEG +: SEG] + {{(SEG-1){1'b0}}, w_src[k].carry};
      w_nxt[k].carry = w_rc[k] | (w_src[k].carry & (&w_z[k*SEG +: SEG]));
    end
  end

  // Ready ripples back from the consumer; an empty stage always accepts.
  always_comb begin : p_ctrl
    logic w_rdy;
    w_rdy  = out_ready;
    w_adv  = '0;
    w_load = '0;
    for (int k = NSEG-1; k >= 0; k--) begin
      w_adv[k]  = r_stg[k].valid & w_rdy;
      w_load[k] = ~r_stg[k].valid | w_adv[k];
      w_rdy     = w_load[k];
    end
  end

  assign in_ready = w_load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        r_stg[k].valid <= 1'b0;
      end
      r_stg[NSEG-1].sum   <= '0;
      r_stg[NSEG-1].carry <= 1'b0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (w_load[k]) begin
          if (w_nxt[k].valid) r_stg[k] <= w_nxt[k];
          else                r_stg[k].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_stg[NSEG-1].valid;
  assign sum       = r_stg[NSEG-1].sum;
  assign cout      = r_stg[NSEG-1].carry;

`ifdef CSLA_SEG_PIPE_OVF_EN
  logic r_ovf;

  // Same-sign operands whose result sign differs is a signed overflow, carry-in included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_load[NSEG-1] && w_nxt[NSEG-1].valid) begin
      r_ovf <= (w_nxt[NSEG-1].a[WIDTH-1] == w_nxt[NSEG-1].b[WIDTH-1]) &&
               (w_nxt[NSEG-1].sum[WIDTH-1] != w_nxt[NSEG-1].a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  logic w_unused;
  assign w_unused = ^{r_stg[NSEG-1].a, r_stg[NSEG-1].b};

endmodule

// File: tb/tb_csla_seg_pipe.sv
// Directed self-checking bench for csla_seg_pipe (WIDTH=16, SEG=4); checks ovf when CSLA_SEG_PIPE_OVF_EN is defined.
module tb_csla_seg_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CSLA_SEG_PIPE_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  csla_seg_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSLA_SEG_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream vectors with hand-computed {cout, sum} and signed overflow.
  logic [15:0] s_a   [8] = '{16'h00FF, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h8000, 16'h0F0F, 16'hABCD, 16'h7FFF};
  logic [15:0] s_b   [8] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h4321, 16'h8000, 16'hF0F0, 16'h1111, 16'h0001};
  logic        s_c   [8] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
  logic [16:0] s_exp [8] = '{17'h00100, 17'h10000, 17'h1FFFF, 17'h05555, 17'h10000, 17'h10000, 17'h0BCDF, 17'h08000};
  logic        s_ovf [8] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};

  logic [15:0] f_a   [5] = '{16'h0001, 16'hFFF0, 16'h1000, 16'h00FF, 16'h5A5A};
  logic [15:0] f_b   [5] = '{16'h0002, 16'h0010, 16'h2000, 16'hFF01, 16'hA5A5};
  logic        f_c   [5] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
  logic [16:0] f_exp [5] = '{17'h00003, 17'h10000, 17'h03001, 17'h10000, 17'h0FFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum_cout", {15'd0, cout, sum}, 32'd0);
`ifdef CSLA_SEG_PIPE_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single beat: latency of exactly four cycles.
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("lat_not_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_result", {15'd0, cout, sum}, 32'h00100);
    step();
    chk("lat_no_dup", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream of eight beats.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; a = s_a[c]; b = s_b[c]; cin = s_c[c];
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk($sformatf("stream_valid_c%0d", c), {31'd0, out_valid}, {31'd0, (c >= 3 && c <= 10)});
      if (c >= 3 && c <= 10) begin
        chk($sformatf("stream_res_%0d", c-3), {15'd0, cout, sum}, {15'd0, s_exp[c-3]});
`ifdef CSLA_SEG_PIPE_OVF_EN
        chk($sformatf("stream_ovf_%0d", c-3), {31'd0, ovf}, {31'd0, s_ovf[c-3]});
`endif
      end
    end

    // Fill with consumer stalled, then release.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; a = f_a[idx]; b = f_b[idx]; cin = f_c[idx];
      #1 acc = in_valid & in_ready;
      step();
      if (acc) idx++;
      if (c >= 3) begin
        chk($sformatf("stall_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
        chk($sformatf("stall_sum_c%0d", c), {15'd0, cout, sum}, {15'd0, f_exp[0]});
      end
    end
    chk("stall_accepted", idx, 32'd4);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);

    out_ready = 1'b1;
    #1 chk("full_accept_emit", {31'd0, in_ready}, 32'd1);
    for (int it = 0; it < 8; it++) begin
      in_valid = (idx < 5);
      if (idx < 5) begin
        a = f_a[idx]; b = f_b[idx]; cin = f_c[idx];
      end
      #1 acc = in_valid & in_ready;
      chk($sformatf("drain_valid_%0d", it), {31'd0, out_valid}, {31'd0, (it < 5)});
      if (it < 5) chk($sformatf("drain_res_%0d", it), {15'd0, cout, sum}, {15'd0, f_exp[it]});
      step();
      if (acc) idx++;
    end
    chk("drain_accepted", idx, 32'd5);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = s_a[c]; b = s_b[c]; cin = s_c[c];
      step();
    end
    in_valid = 1'b0;
    step();
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_sum", {15'd0, cout, sum}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("no_stale_c%0d", c), {31'd0, out_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
